// File: rtl/m_dmem_responder_if.sv
// Load/store channel between the memory-access stage (master) and the data memory (slave).
// Requests and responses each use their own valid/ready pair.
interface m_dmem_responder_if;
    logic        w_req_valid;
    logic        w_req_ready;
    logic        w_req_we;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_wdata;
    logic [3:0]  w_req_be;
    logic        w_rsp_valid;
    logic        w_rsp_ready;
    logic [31:0] w_rsp_rdata;
    logic        w_rsp_err;

    modport master (
        output w_req_valid, w_req_we, w_req_addr, w_req_wdata, w_req_be, w_rsp_ready,
        input  w_req_ready, w_rsp_valid, w_rsp_rdata, w_rsp_err
    );

    modport slave (
        input  w_req_valid, w_req_we, w_req_addr, w_req_wdata, w_req_be, w_rsp_ready,
        output w_req_ready, w_rsp_valid, w_rsp_rdata, w_rsp_err
    );
endinterface

// File: rtl/m_dmem_responder.sv
// Data-memory responder with programmable wait latency. It handles one transaction at a
// time: accept, wait LATENCY cycles, execute the load or byte-masked store, then respond.
module m_dmem_responder #(
    parameter int ADDR_WORDS = 64,
    parameter int LATENCY    = 2
) (
    input  logic                 w_clock,
    input  logic                 w_reset,
    m_dmem_responder_if.slave    bus,
    output logic                 w_busy
);
    localparam int IDX_W = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  count;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic        err_q;

    // NOTE: memory has no reset; it powers up zeroed and keeps its contents across w_reset.
    logic [31:0] mem [ADDR_WORDS] = '{default: '0};

    logic             accept;
    logic             execute;
    logic             op_we;
    logic [31:0]      op_addr;
    logic [31:0]      op_wdata;
    logic [3:0]       op_be;
    logic             op_err;
    logic [IDX_W-1:0] op_idx;

    assign bus.w_req_ready = (state == IDLE) && !w_reset;
    assign accept          = bus.w_req_valid && bus.w_req_ready;
    assign bus.w_rsp_valid = (state == RESP);
    assign bus.w_rsp_rdata = rdata_q;
    assign bus.w_rsp_err   = err_q;
    assign w_busy          = (state != IDLE);

    // With zero latency the execute edge is the accept edge, so operands come straight from the bus.
    assign op_we    = (state == IDLE) ? bus.w_req_we    : we_q;
    assign op_addr  = (state == IDLE) ? bus.w_req_addr  : addr_q;
    assign op_wdata = (state == IDLE) ? bus.w_req_wdata : wdata_q;
    assign op_be    = (state == IDLE) ? bus.w_req_be    : be_q;
    assign op_err   = (op_addr[1:0] != 2'b00) || (op_addr[31:2] >= 30'(ADDR_WORDS));
    assign op_idx   = op_addr[IDX_W+1:2];

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        execute    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_next = RESP;
                        execute    = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    state_next = RESP;
                    execute    = 1'b1;
                end
            end
            RESP: begin
                if (bus.w_rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            state   <= IDLE;
            count   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q    <= bus.w_req_we;
                addr_q  <= bus.w_req_addr;
                wdata_q <= bus.w_req_wdata;
                be_q    <= bus.w_req_be;
                if (LATENCY != 0) count <= 4'(LATENCY - 1);
            end else if (state == WAIT && count != 4'd0) begin
                count <= count - 4'd1;
            end
            if (execute) begin
                rdata_q <= (op_we || op_err) ? 32'd0 : mem[op_idx];
                err_q   <= op_err;
            end
        end
    end

    // Reset in WAIT drops a pending store; a store that already reached RESP has committed.
    always_ff @(posedge w_clock) begin
        if (execute && op_we && !op_err && !w_reset) begin
            for (int k = 0; k < 4; k++) begin
                if (op_be[k]) mem[op_idx][8*k +: 8] <= op_wdata[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_m_dmem_responder.sv
// Bench for m_dmem_responder: one instance at LATENCY=0 (sel 0) and one at LATENCY=2 (sel 1),
// both checked against a word-array model plus directed expectations.
module tb_m_dmem_responder;
    logic w_clock = 1'b0;
    logic w_reset = 1'b1;
    logic busy0, busy2;
    int   checks = 0;
    int   errors = 0;

    always #5 w_clock = ~w_clock;

    m_dmem_responder_if bus0();
    m_dmem_responder_if bus2();

    m_dmem_responder #(.ADDR_WORDS(64), .LATENCY(0)) dut0 (
        .w_clock(w_clock), .w_reset(w_reset), .bus(bus0), .w_busy(busy0));
    m_dmem_responder #(.ADDR_WORDS(64), .LATENCY(2)) dut2 (
        .w_clock(w_clock), .w_reset(w_reset), .bus(bus2), .w_busy(busy2));

    logic [31:0] mdl [2][64];

    typedef struct {
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rdata;
        logic        err;
        logic        busy;
    } obs_t;

    typedef struct {
        int          sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge w_clock);
        #1;
    endtask

    function automatic obs_t observe(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.req_ready = bus0.w_req_ready; o.rsp_valid = bus0.w_rsp_valid;
            o.rdata = bus0.w_rsp_rdata; o.err = bus0.w_rsp_err; o.busy = busy0;
        end else begin
            o.req_ready = bus2.w_req_ready; o.rsp_valid = bus2.w_rsp_valid;
            o.rdata = bus2.w_rsp_rdata; o.err = bus2.w_rsp_err; o.busy = busy2;
        end
        return o;
    endfunction

    task automatic drive_req(input int sel, input logic v, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        if (sel == 0) begin
            bus0.w_req_valid = v; bus0.w_req_we = we; bus0.w_req_addr = addr;
            bus0.w_req_wdata = wdata; bus0.w_req_be = be;
        end else begin
            bus2.w_req_valid = v; bus2.w_req_we = we; bus2.w_req_addr = addr;
            bus2.w_req_wdata = wdata; bus2.w_req_be = be;
        end
    endtask

    task automatic drive_rsp_ready(input int sel, input logic r);
        if (sel == 0) bus0.w_rsp_ready = r;
        else          bus2.w_rsp_ready = r;
    endtask

    // Reference: memory is a plain array of words; a transaction is one atomic step.
    function automatic void model_exec(input int sel, input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] be,
                                       output logic [31:0] rdata, output logic err);
        int unsigned word = addr / 4;
        err   = (addr % 4 != 0) || (word >= 64);
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < 4; k++)
                    if (be[k]) mdl[sel][word][8*k +: 8] = wdata[8*k +: 8];
            end else begin
                rdata = mdl[sel][word];
            end
        end
    endfunction

    task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold,
                       output logic [31:0] got_rdata, output logic got_err);
        obs_t        o, first;
        int          n;
        int          lat;
        logic [31:0] e_rd;
        logic        e_err;
        lat       = (sel == 0) ? 0 : 2;
        got_rdata = 32'd0;
        got_err   = 1'b0;
        drive_req(sel, 1'b1, we, addr, wdata, be);
        n = 0;
        o = observe(sel);
        while (!o.req_ready && n < 20) begin
            step(); n++; o = observe(sel);
        end
        if (!o.req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            drive_req(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
            return;
        end
        step();
        model_exec(sel, we, addr, wdata, be, e_rd, e_err);
        drive_req(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        n = 0;
        o = observe(sel);
        while (!o.rsp_valid && n < 40) begin
            step(); n++; o = observe(sel);
        end
        check("rsp_latency", n, lat);
        if (!o.rsp_valid) return;
        check("rsp_rdata", o.rdata, e_rd);
        check("rsp_err", {31'd0, o.err}, {31'd0, e_err});
        got_rdata = o.rdata;
        got_err   = o.err;
        first     = o;
        // A junk store is offered while the response is held; it must never be taken.
        if (hold > 0) drive_req(sel, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
        for (int h = 0; h < hold; h++) begin
            step();
            o = observe(sel);
            check("hold_valid", {31'd0, o.rsp_valid}, 32'd1);
            check("hold_rdata", o.rdata, first.rdata);
            check("hold_err", {31'd0, o.err}, {31'd0, first.err});
            check("hold_req_ready", {31'd0, o.req_ready}, 32'd0);
        end
        drive_rsp_ready(sel, 1'b1);
        step();
        drive_rsp_ready(sel, 1'b0);
        drive_req(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        o = observe(sel);
        check("post_req_ready", {31'd0, o.req_ready}, 32'd1);
        check("post_busy", {31'd0, o.busy}, 32'd0);
        check("post_rsp_valid", {31'd0, o.rsp_valid}, 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        req_t        reqs[6];
        obs_t        o;
        logic [31:0] rd, e_rd;
        logic        er, e_err;
        logic [31:0] exp_rd_q[$];
        logic        exp_err_q[$];
        int          idx, last_acc, cyc, got_rsp;

        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 64; w++) mdl[s][w] = 32'd0;
        for (int s = 0; s < 2; s++) begin
            drive_req(s, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
            drive_rsp_ready(s, 1'b0);
        end

        // Reset state
        repeat (3) step();
        for (int s = 0; s < 2; s++) begin
            o = observe(s);
            check("rst_req_ready", {31'd0, o.req_ready}, 32'd0);
            check("rst_rsp_valid", {31'd0, o.rsp_valid}, 32'd0);
            check("rst_busy", {31'd0, o.busy}, 32'd0);
            check("rst_rdata", o.rdata, 32'd0);
            check("rst_err", {31'd0, o.err}, 32'd0);
        end
        w_reset = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            o = observe(s);
            check("post_rst_req_ready", {31'd0, o.req_ready}, 32'd1);
        end

        // Directed vectors on the LATENCY=2 instance
        vecs.push_back('{1, 1'b1, 32'h10,  32'hDEAD_BEEF, 4'hF, 0, 32'h0,         1'b0});
        vecs.push_back('{1, 1'b0, 32'h10,  32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1, 1'b1, 32'h10,  32'h1122_3344, 4'h5, 0, 32'h0,         1'b0});
        vecs.push_back('{1, 1'b0, 32'h10,  32'h0,         4'h0, 0, 32'hDE22_BE44, 1'b0});
        vecs.push_back('{1, 1'b1, 32'h10,  32'hFFFF_FFFF, 4'h0, 0, 32'h0,         1'b0});
        vecs.push_back('{1, 1'b0, 32'h10,  32'h0,         4'h0, 0, 32'hDE22_BE44, 1'b0});
        vecs.push_back('{1, 1'b0, 32'h12,  32'h0,         4'h0, 0, 32'h0,         1'b1});
        vecs.push_back('{1, 1'b1, 32'h100, 32'hAAAA_AAAA, 4'hF, 0, 32'h0,         1'b1});
        vecs.push_back('{1, 1'b0, 32'hFC,  32'h0,         4'h0, 0, 32'h0,         1'b0});
        vecs.push_back('{1, 1'b0, 32'h10,  32'h0,         4'h0, 5, 32'hDE22_BE44, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h8,   32'hCAFE_F00D, 4'hC, 2, 32'h0,         1'b0});
        vecs.push_back('{0, 1'b0, 32'h8,   32'h0,         4'h0, 0, 32'hCAFE_0000, 1'b0});
        foreach (vecs[i]) begin
            txn(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].hold, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
        end

        // Back-to-back requests on the LATENCY=0 instance, valid held high throughout
        reqs[0] = '{1'b1, 32'h40, 32'h0000_0123, 4'hF};
        reqs[1] = '{1'b0, 32'h40, 32'h0,         4'h0};
        reqs[2] = '{1'b1, 32'h44, $urandom,      4'h3};
        reqs[3] = '{1'b0, 32'h44, 32'h0,         4'h0};
        reqs[4] = '{1'b0, 32'h41, 32'h0,         4'h0};
        reqs[5] = '{1'b0, 32'h40, 32'h0,         4'h0};
        idx = 0; last_acc = -1; cyc = 0; got_rsp = 0;
        drive_rsp_ready(0, 1'b1);
        drive_req(0, 1'b1, reqs[0].we, reqs[0].addr, reqs[0].wdata, reqs[0].be);
        while (got_rsp < 6 && cyc < 60) begin
            o = observe(0);
            if (o.rsp_valid) begin
                if (exp_rd_q.size() == 0) begin
                    check("b2b_extra_rsp", 32'd1, 32'd0);
                end else begin
                    e_rd  = exp_rd_q.pop_front();
                    e_err = exp_err_q.pop_front();
                    check("b2b_rdata", o.rdata, e_rd);
                    check("b2b_err", {31'd0, o.err}, {31'd0, e_err});
                end
                got_rsp++;
            end
            if (o.req_ready && idx < 6) begin
                if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, 32'd2);
                last_acc = cyc;
                model_exec(0, reqs[idx].we, reqs[idx].addr, reqs[idx].wdata, reqs[idx].be, e_rd, e_err);
                exp_rd_q.push_back(e_rd);
                exp_err_q.push_back(e_err);
                idx++;
            end
            step();
            cyc++;
            if (idx < 6) drive_req(0, 1'b1, reqs[idx].we, reqs[idx].addr, reqs[idx].wdata, reqs[idx].be);
            else         drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        end
        check("b2b_rsp_count", got_rsp, 32'd6);
        drive_rsp_ready(0, 1'b0);
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        step();

        // Reset while a store sits in WAIT on the LATENCY=2 instance
        drive_req(1, 1'b1, 1'b1, 32'h20, 32'h5, 4'hF);
        o = observe(1);
        check("rstw_pre_ready", {31'd0, o.req_ready}, 32'd1);
        step();
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        o = observe(1);
        check("rstw_busy_in_wait", {31'd0, o.busy}, 32'd1);
        w_reset = 1'b1;
        step();
        o = observe(1);
        check("rstw_busy_after", {31'd0, o.busy}, 32'd0);
        check("rstw_rsp_valid", {31'd0, o.rsp_valid}, 32'd0);
        check("rstw_req_ready", {31'd0, o.req_ready}, 32'd0);
        w_reset = 1'b0;
        repeat (4) begin
            step();
            o = observe(1);
            check("rstw_no_rsp", {31'd0, o.rsp_valid}, 32'd0);
        end
        txn(1, 1'b0, 32'h20, 32'd0, 4'd0, 0, rd, er);
        check("rstw_load_0x20", rd, 32'd0);

        // Randomized traffic on both instances against the model
        for (int i = 0; i < 60; i++) begin
            int          sel, r;
            logic        we;
            logic [31:0] addr;
            sel = $urandom_range(0, 1);
            we  = 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 9);
            if (r == 0)      addr = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
            else if (r == 1) addr = 32'($urandom_range(64, 70)) * 4;
            else             addr = 32'($urandom_range(0, 7)) * 4;
            txn(sel, we, addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), rd, er);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
